m92_inta_seq: RTL

M92_INTA_SEQ -- requirements
Module: m92_inta_seq

---
 rtl/m92_inta_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/m92_inta_seq.sv
// m92_inta_seq: interrupt acknowledge sequencer between the interrupt
// controller and the CPU core. A pending request is latched, cpu_intr is
// raised, and the vector is presented on the second of two INTA bus cycles.
// Optional build macro: M92_INTA_TIMEOUT_EN. When it is defined, a stalled
// PEND/INTA1 handshake gives up after 255 ce cycles and returns to IDLE.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request in flight; waiting for pic_int_req
// PEND    | vector latched, cpu_intr asserted, waiting for first INTA
// INTA1   | dummy first INTA cycle seen; waiting for the second INTA
// INTA2   | vector driven on the bus and acknowledged to the PIC (one ce)
// RELEASE | waiting for the PIC to drop its request before re-arming
module m92_inta_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       pic_int_req,
    input  logic [8:0] pic_int_vector,
    output logic       pic_int_ack,
    output logic       cpu_intr,
    input  logic       cpu_inta,
    output logic [7:0] cpu_vector,
    output logic       cpu_vector_oe,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PEND    = 3'd1,
        INTA1   = 3'd2,
        INTA2   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] vec_lat;
    logic       load_vec;

`ifdef M92_INTA_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout;

    // Counts ce cycles spent in PEND/INTA1; restarts on every entry to either.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (ce) begin
            if (state_d != state_q) begin
                wait_cnt <= 8'd0;
            end else if ((state_q == PEND) || (state_q == INTA1)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign timeout = (wait_cnt == 8'd255);
`endif

    // State register; only advances on ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // Vector is captured once, when the request is accepted, and held until the next acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_lat <= 8'h00;
        end else if (load_vec) begin
            vec_lat <= {1'b0, pic_int_vector[8:2]};
        end
    end

    // Next-state decode.
    always_comb begin
        state_d  = state_q;
        load_vec = 1'b0;
        case (state_q)
            IDLE: begin
                if (ce && pic_int_req) begin
                    state_d  = PEND;
                    load_vec = 1'b1;
                end
            end
            PEND: begin
                // A request dropped here is still delivered; the CPU has committed.
                if (cpu_inta) begin
                    state_d = INTA1;
                end
`ifdef M92_INTA_TIMEOUT_EN
                else if (timeout) begin
                    state_d = IDLE;
                end
`endif
            end
            INTA1: begin
                if (cpu_inta) begin
                    state_d = INTA2;
                end
`ifdef M92_INTA_TIMEOUT_EN
                else if (timeout) begin
                    state_d = IDLE;
                end
`endif
            end
            INTA2: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!pic_int_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so they hold while ce=0
    // and drop to their idle values the moment reset asserts.
    always_comb begin
        cpu_intr      = (state_q == PEND);
        cpu_vector_oe = (state_q == INTA2);
        pic_int_ack   = (state_q == INTA2);
        cpu_vector    = (state_q == INTA2) ? vec_lat : 8'h00;
        busy          = (state_q != IDLE);
    end

endmodule
